sseg_freq_display: RTL and testbench



---
 rtl/sseg_freq_display_if.sv | 22 ++
 rtl/sseg_freq_display.sv | 92 +++++++++
 tb/tb_sseg_freq_display.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sseg_freq_display_if.sv
// Display bundle between the frequency-counter result and the seven-segment driver.
// The master side supplies the BCD result and enable; the slave side drives the board lines.
interface sseg_freq_display_if;
    logic       en;
    logic [3:0] bcd3;
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
    logic [1:0] decimal_counter;
    logic [3:0] an;
    logic [7:0] sseg;

    modport master (
        output en, bcd3, bcd2, bcd1, bcd0, decimal_counter,
        input  an, sseg
    );

    modport slave (
        input  en, bcd3, bcd2, bcd1, bcd0, decimal_counter,
        output an, sseg
    );
endinterface

// File: rtl/sseg_freq_display.sv
// Four-digit multiplexed seven-segment driver for the frequency counter result.
// The result is snapshotted once per scan (on the all-ones refresh count) so a
// result update never tears mid-scan; leading integer zeros are blanked and the
// decimal point is placed from the snapshotted position.
module sseg_freq_display #(
    parameter int N = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    sseg_freq_display_if.slave   disp
);

    logic [N-1:0] q_q, q_d;
    logic [15:0]  snap_q, snap_d;
    logic [1:0]   sk_q, sk_d;
    logic [3:0]   an_q, an_d;
    logic [7:0]   sseg_q, sseg_d;

    logic [1:0]   sel;
    logic [1:0]   dp_pos;
    logic [3:0]   digit;
    logic [3:0]   lz;
    logic         dp_on;
    logic         blank;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h3F;
        endcase
    endfunction

    // Refresh counter advance and once-per-scan snapshot load on the all-ones count.
    always_comb begin
        q_d    = q_q + 1'b1;
        snap_d = snap_q;
        sk_d   = sk_q;
        if (q_q == '1) begin
            snap_d = {disp.bcd3, disp.bcd2, disp.bcd1, disp.bcd0};
            sk_d   = disp.decimal_counter;
        end
    end

    // Digit selection, leading-zero detection and decimal-point placement.
    always_comb begin
        sel    = q_q[N-1:N-2];
        dp_pos = 2'd3 - sk_q;
        digit  = snap_q[{sel, 2'b00} +: 4];
        lz[3]  = (snap_q[15:12] == 4'd0);
        lz[2]  = lz[3] && (snap_q[11:8] == 4'd0);
        lz[1]  = lz[2] && (snap_q[7:4] == 4'd0);
        lz[0]  = lz[1] && (snap_q[3:0] == 4'd0);
        dp_on  = (sel == dp_pos);
        blank  = (sel > dp_pos) && lz[sel];
    end

    // Next anode and segment values for the digit currently selected.
    always_comb begin
        an_d   = disp.en ? ~(4'b0001 << sel) : 4'b1111;
        sseg_d = {~dp_on, (blank ? 7'h7F : seg7(digit))};
    end

    // State registers; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            snap_q <= '0;
            sk_q   <= '0;
            an_q   <= 4'b1111;
            sseg_q <= 8'hFF;
        end else begin
            q_q    <= q_d;
            snap_q <= snap_d;
            sk_q   <= sk_d;
            an_q   <= an_d;
            sseg_q <= sseg_d;
        end
    end

    assign disp.an   = an_q;
    assign disp.sseg = sseg_q;

endmodule

// File: tb/tb_sseg_freq_display.sv
// Self-checking bench for sseg_freq_display with a short refresh counter.
// A reference model tracks scan position and the displayed snapshot and
// predicts the registered anode/segment lines after every edge.
module tb_sseg_freq_display;
    localparam int N     = 4;
    localparam int SCAN  = 1 << N;
    localparam int DWELL = SCAN / 4;

    logic clk = 1'b0;
    logic reset;

    sseg_freq_display_if dif();

    sseg_freq_display #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (dif.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int m_q;
    int snap[4];
    int snap_k;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0:       return 7'h40;
            1:       return 7'h79;
            2:       return 7'h24;
            3:       return 7'h30;
            4:       return 7'h19;
            5:       return 7'h12;
            6:       return 7'h02;
            7:       return 7'h78;
            8:       return 7'h00;
            9:       return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [7:0] exp_sseg(input int i);
        int dp_pos;
        int upper;
        bit blank;
        logic [6:0] g;
        dp_pos = 3 - snap_k;
        upper  = 0;
        for (int j = 3; j >= i; j--) upper += snap[j];
        blank = (i > dp_pos) && (upper == 0);
        g = blank ? 7'h7F : glyph(snap[i]);
        return {((i == dp_pos) ? 1'b0 : 1'b1), g};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        logic [3:0] ea;
        logic [7:0] es;
        int sel;
        sel = m_q / DWELL;
        if (reset) begin
            ea = 4'hF;
            es = 8'hFF;
        end else begin
            ea = dif.en ? 4'(15 - (1 << sel)) : 4'hF;
            es = exp_sseg(sel);
        end
        if (reset) begin
            m_q    = 0;
            snap   = '{default: 0};
            snap_k = 0;
        end else begin
            if (m_q == SCAN - 1) begin
                snap[3] = int'(dif.bcd3);
                snap[2] = int'(dif.bcd2);
                snap[1] = int'(dif.bcd1);
                snap[0] = int'(dif.bcd0);
                snap_k  = int'(dif.decimal_counter);
            end
            m_q = (m_q + 1) % SCAN;
        end
        @(posedge clk);
        #1;
        chk($sformatf("an sel%0d", sel), {4'h0, dif.an}, {4'h0, ea});
        chk($sformatf("sseg sel%0d", sel), dif.sseg, es);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_in(input int d3, input int d2, input int d1, input int d0, input int k);
        dif.bcd3            = 4'(d3);
        dif.bcd2            = 4'(d2);
        dif.bcd1            = 4'(d1);
        dif.bcd0            = 4'(d0);
        dif.decimal_counter = 2'(k);
    endtask

    task automatic goto_sel(input int s);
        for (int i = 0; i < SCAN && (m_q / DWELL) != s; i++) tick();
    endtask

    function automatic int rnd_digit();
        return ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 15));
    endfunction

    initial begin
        m_q    = 0;
        snap   = '{default: 0};
        snap_k = 0;
        reset  = 1'b1;
        dif.en = 1'b1;
        set_in(0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;

        tick();
        chk("post_reset an", {4'h0, dif.an}, 8'h0E);
        chk("post_reset sseg", dif.sseg, 8'hC0);

        set_in(1, 2, 3, 4, 3);
        run(2 * SCAN);

        set_in(0, 0, 5, 7, 3);
        run(2 * SCAN);

        set_in(0, 0, 0, 0, 1);
        run(2 * SCAN);

        set_in(1, 1, 1, 1, 2);
        run(2 * SCAN);
        goto_sel(1);
        set_in(2, 2, 2, 2, 2);
        run(2 * SCAN);

        set_in(9, 8, 7, 6, 0);
        run(SCAN);
        goto_sel(1);
        tick();
        dif.en = 1'b0;
        run(10);
        dif.en = 1'b1;
        run(SCAN);

        goto_sel(2);
        reset = 1'b1;
        tick();
        chk("mid_reset an", {4'h0, dif.an}, 8'h0F);
        chk("mid_reset sseg", dif.sseg, 8'hFF);
        reset = 1'b0;
        tick();
        chk("after_reset an", {4'h0, dif.an}, 8'h0E);
        chk("after_reset sseg", dif.sseg, 8'hC0);

        set_in(5, 0, 12, 0, 2);
        run(2 * SCAN);

        for (int r = 0; r < 40; r++) begin
            set_in(rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit(), int'($urandom_range(0, 3)));
            dif.en = ($urandom_range(0, 4) != 0);
            run(int'($urandom_range(1, 40)));
        end
        dif.en = 1'b1;
        run(2 * SCAN);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
